clock_mode_ctrl: RTL and testbench

Top-level user-interface sequencer for the digital clock. Takes debounced single-cycle key pulses and selects the operating mode: run, set time or set alarm. It also selects the field being adjusted and routes "add" presses to the time-set or alarm-set adjusters. It produces per-field display blink masks and returns to run mode after an inactivity timeout.

---
 rtl/clock_pkg.sv | 35 +++
 rtl/clock_mode_ctrl_if.sv | 31 +++
 rtl/blink_gen.sv | 45 ++++
 rtl/clock_mode_ctrl.sv | 106 ++++++++++
 tb/tb_clock_mode_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the digital-clock user interface.
//   mode_e  : operating mode (RUN / SET_TIME / SET_ALARM)
//   field_e : field being adjusted (sec / min / hour), never 3
//   next_mode / next_field : wrap-around advance helpers
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN       = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      FIELD_SEC  = 2'd0,
      FIELD_MIN  = 2'd1,
      FIELD_HOUR = 2'd2
   } field_e;

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_RUN:      return MODE_SET_TIME;
         MODE_SET_TIME: return MODE_SET_ALARM;
         default:       return MODE_RUN;
      endcase
   endfunction

   function automatic field_e next_field(input field_e f);
      case (f)
         FIELD_SEC: return FIELD_MIN;
         FIELD_MIN: return FIELD_HOUR;
         default:   return FIELD_SEC;
      endcase
   endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Key/strobe inputs and UI control outputs of clock_mode_ctrl.
//   master : drives tick_1hz and key pulses, observes the outputs
//   slave  : the controller (receives keys, drives mode/field/pulses/mask)
interface clock_mode_ctrl_if;
   import clock_pkg::*;

   logic       tick_1hz;
   logic       key_mode;
   logic       key_sel;
   logic       key_add;
   mode_e      mode;
   logic       run_en;
   field_e     field_sel;
   logic       time_adj_pulse;
   logic       alarm_adj_pulse;
   logic       alarm_armed;
   logic [2:0] blink_mask;

   modport master (
      output tick_1hz, key_mode, key_sel, key_add,
      input  mode, run_en, field_sel, time_adj_pulse, alarm_adj_pulse,
             alarm_armed, blink_mask
   );

   modport slave (
      input  tick_1hz, key_mode, key_sel, key_add,
      output mode, run_en, field_sel, time_adj_pulse, alarm_adj_pulse,
             alarm_armed, blink_mask
   );

endinterface

// File: rtl/blink_gen.sv
// Blink phase generator: a 0..HALF-1 cycle counter that toggles phase on
// wrap. restart forces counter=0 and phase=visible (1).
//   clk, rst_n : clock, async active-low reset (phase resets visible)
//   restart    : 1-cycle restart request
//   phase      : registered blink phase, 1=visible
module blink_gen #(
   parameter int unsigned HALF = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic phase
);

   localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// UI sequencer for the digital clock: mode FSM (RUN/SET_TIME/SET_ALARM),
// field select, routing of add presses, inactivity timeout and blink masks.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of clock_mode_ctrl_if (keys/tick in, controls out)
// Every output is a flop or a decode of flops only; key response is one cycle.
import clock_pkg::*;

module clock_mode_ctrl #(
   parameter int unsigned TIMEOUT_S  = 30,
   parameter int unsigned BLINK_HALF = 25_000_000
) (
   input logic               clk,
   input logic               rst_n,
   clock_mode_ctrl_if.slave  bus
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);

   mode_e      mode_q, mode_d;
   field_e     field_q, field_d;
   logic       tadj_q, tadj_d;
   logic       aadj_q, aadj_d;
   logic       armed_q, armed_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic       any_key, in_set, phase;

   assign any_key = bus.key_mode | bus.key_sel | bus.key_add;
   assign in_set  = (mode_q != MODE_RUN);

   always_comb begin
      mode_d  = mode_q;
      field_d = field_q;
      tadj_d  = 1'b0;
      aadj_d  = 1'b0;
      armed_d = armed_q;
      tcnt_d  = tcnt_q;

      // Priority mode > sel > add; losers in the same cycle are dropped.
      if (bus.key_mode) begin
         mode_d  = next_mode(mode_q);
         field_d = FIELD_SEC;
      end else if (bus.key_sel) begin
         if (in_set) field_d = next_field(field_q);
      end else if (bus.key_add) begin
         case (mode_q)
            MODE_SET_TIME:  tadj_d  = 1'b1;
            MODE_SET_ALARM: aadj_d  = 1'b1;
            default:        armed_d = ~armed_q;
         endcase
      end

      // A key in the expiring cycle wins, so the key check comes first.
      if (!in_set || any_key) begin
         tcnt_d = '0;
      end else if (bus.tick_1hz) begin
         if (tcnt_q == TO_LAST) begin
            tcnt_d  = '0;
            mode_d  = MODE_RUN;
            field_d = FIELD_SEC;
         end else begin
            tcnt_d = tcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_RUN;
         field_q <= FIELD_SEC;
         tadj_q  <= 1'b0;
         aadj_q  <= 1'b0;
         armed_q <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         field_q <= field_d;
         tadj_q  <= tadj_d;
         aadj_q  <= aadj_d;
         armed_q <= armed_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Any press restarts the blink so the edited field stays lit while pressed.
   blink_gen #(.HALF(BLINK_HALF)) u_blink (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (any_key),
      .phase   (phase)
   );

   logic [2:0] mask;
   always_comb begin
      mask = 3'b111;
      if (in_set) mask[field_q] = phase;
   end

   assign bus.mode            = mode_q;
   assign bus.run_en          = ~in_set;
   assign bus.field_sel       = field_q;
   assign bus.time_adj_pulse  = tadj_q;
   assign bus.alarm_adj_pulse = aadj_q;
   assign bus.alarm_armed     = armed_q;
   assign bus.blink_mask      = mask;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

   localparam int TO = 3;
   localparam int BH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   clock_mode_ctrl_if bus();

   clock_mode_ctrl #(.TIMEOUT_S(TO), .BLINK_HALF(BH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: plain integers describing what the user should see.
   int mm, mf, marmed, idle_ticks, bcyc, ph, exp_t, exp_a;

   function automatic int exp_mask();
      if (mm == 0) return 7;
      return (7 & ~(1 << mf)) | (ph << mf);
   endfunction

   task automatic model_reset();
      mm = 0; mf = 0; marmed = 0; idle_ticks = 0;
      bcyc = 0; ph = 1; exp_t = 0; exp_a = 0;
   endtask

   task automatic model_step(input bit m, input bit s, input bit a, input bit t);
      bit any_k;
      bit was_set;
      any_k   = m | s | a;
      was_set = (mm != 0);
      exp_t = 0; exp_a = 0;
      if (m) begin
         mm = (mm + 1) % 3; mf = 0;
      end else if (s) begin
         if (mm != 0) mf = (mf + 1) % 3;
      end else if (a) begin
         if (mm == 0) marmed = 1 - marmed;
         else if (mm == 1) exp_t = 1;
         else exp_a = 1;
      end
      if (!was_set || any_k) idle_ticks = 0;
      else if (t) begin
         idle_ticks++;
         if (idle_ticks == TO) begin
            mm = 0; mf = 0; idle_ticks = 0;
         end
      end
      if (any_k) begin
         bcyc = 0; ph = 1;
      end else begin
         bcyc++;
         if (bcyc == BH) begin
            bcyc = 0; ph = 1 - ph;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("mode",       8'(bus.mode),            8'(mm));
      chk("run_en",     8'(bus.run_en),          8'(mm == 0));
      chk("field_sel",  8'(bus.field_sel),       8'(mf));
      chk("time_adj",   8'(bus.time_adj_pulse),  8'(exp_t));
      chk("alarm_adj",  8'(bus.alarm_adj_pulse), 8'(exp_a));
      chk("armed",      8'(bus.alarm_armed),     8'(marmed));
      chk("blink_mask", 8'(bus.blink_mask),      8'(exp_mask()));
   endtask

   task automatic cyc(input bit m, input bit s, input bit a, input bit t);
      bus.key_mode = m; bus.key_sel = s; bus.key_add = a; bus.tick_1hz = t;
      @(posedge clk);
      model_step(m, s, a, t);
      #1;
      check_all();
      bus.key_mode = 0; bus.key_sel = 0; bus.key_add = 0; bus.tick_1hz = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   initial begin
      int np, na, guard;
      bit rm, rs, ra, rt;
      rst_n = 1'b0;
      bus.key_mode = 0; bus.key_sel = 0; bus.key_add = 0; bus.tick_1hz = 0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      idle(100);

      // SET_TIME: field select and add routing
      cyc(1, 0, 0, 0);
      chk("enter_set_time", 8'(bus.mode), 8'd1);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("field_two", 8'(bus.field_sel), 8'd2);
      np = 0; na = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0); np += int'(bus.time_adj_pulse); na += int'(bus.alarm_adj_pulse);
         cyc(0, 0, 0, 0); np += int'(bus.time_adj_pulse); na += int'(bus.alarm_adj_pulse);
      end
      chk("time_adj_count", 8'(np), 8'd3);
      chk("alarm_adj_none", 8'(na), 8'd0);
      cyc(0, 1, 0, 0);
      chk("field_wrap", 8'(bus.field_sel), 8'd0);

      // SET_ALARM, back to RUN, arm toggles
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk("alarm_adj_one", 8'(bus.alarm_adj_pulse), 8'd1);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk("arm_on", 8'(bus.alarm_armed), 8'd1);
      cyc(0, 0, 1, 0);
      chk("arm_off", 8'(bus.alarm_armed), 8'd0);

      // Timeout after TO ticks
      cyc(1, 0, 0, 0);
      for (int i = 0; i < TO; i++) begin cyc(0, 0, 0, 1); idle(2); end
      chk("timeout_run", 8'(bus.mode), 8'd0);

      // Key coincident with expiring tick wins
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 1); idle(1);
      cyc(0, 0, 0, 1); idle(1);
      cyc(0, 0, 1, 1);
      chk("key_beats_timeout", 8'(bus.mode), 8'd1);
      chk("key_beats_pulse", 8'(bus.time_adj_pulse), 8'd1);

      // All three keys at once from SET_TIME
      cyc(0, 1, 0, 0);
      cyc(1, 1, 1, 0);
      chk("prio_mode", 8'(bus.mode), 8'd2);
      chk("prio_field", 8'(bus.field_sel), 8'd0);
      chk("prio_no_adj", 8'(bus.alarm_adj_pulse | bus.time_adj_pulse), 8'd0);

      // Blink on field 1 in SET_TIME
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      idle(12);
      guard = 0;
      while (ph != 0 && guard < 20) begin cyc(0, 0, 0, 0); guard++; end
      chk("reach_dark", 8'(ph == 0), 8'd1);
      chk("dark_mask", 8'(bus.blink_mask), 8'b101);
      cyc(0, 0, 1, 0);
      chk("restart_visible", 8'(bus.blink_mask), 8'b111);
      idle(5);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int r;
         r  = int'($urandom_range(0, 15));
         rm = (r == 0);
         rs = (r == 1) || (r == 3);
         ra = (r == 2) || ($urandom_range(0, 31) == 0);
         rt = ($urandom_range(0, 3) == 0);
         cyc(rm, rs, ra, rt);
      end

      // Asynchronous reset mid-sequence
      if (mm == 0) cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
